// File: rtl/product_accumulator.sv
// Accumulates a programmable number of 32-bit unsigned products into an ACC_W-bit sum
// and hands the block sum plus a sticky carry-out flag to a downstream consumer.
module product_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      prod,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] len,
  input  logic             clr,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic             in_xfer;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W:0]   sum_wide;

  function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] a,
                                               input logic [31:0]      b);
    return {1'b0, a} + (ACC_W+1)'(b);
  endfunction

  // Handshake outputs depend on state only; rst gates them so nothing is offered in reset.
  assign in_ready  = !rst && (state_q != DONE);
  assign out_valid = !rst && (state_q == DONE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

  assign in_xfer  = in_valid && in_ready;
  assign len_eff  = (len == '0) ? CNT_W'(1) : len;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign sum_wide = add_carry(acc_q, prod);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          acc_d   = ACC_W'(prod);
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(1);
          len_d   = len_eff;
          state_d = (len_eff == CNT_W'(1)) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          acc_d = sum_wide[ACC_W-1:0];
          ovf_d = ovf_q | sum_wide[ACC_W];
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides any transfer happening on the same edge.
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      len_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 40-bit and a 32-bit instance share one stimulus stream
// and are checked every cycle against a block-sum model, plus literal expectations.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [31:0] prod;
  logic [7:0]  len;

  logic        in_ready40, out_valid40, ovf40;
  logic [39:0] acc40;
  logic        in_ready32, out_valid32, ovf32;
  logic [31:0] acc32;

  int n_chk  = 0;
  int n_fail = 0;

  localparam longint unsigned M40 = 64'h00FF_FFFF_FFFF;
  localparam longint unsigned M32 = 64'h0000_FFFF_FFFF;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(40), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .prod(prod), .in_valid(in_valid), .in_ready(in_ready40),
    .len(len), .clr(clr), .acc_out(acc40), .ovf(ovf40), .out_valid(out_valid40),
    .out_ready(out_ready)
  );

  product_accumulator #(.ACC_W(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst(rst), .prod(prod), .in_valid(in_valid), .in_ready(in_ready32),
    .len(len), .clr(clr), .acc_out(acc32), .ovf(ovf32), .out_valid(out_valid32),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: block-level view -- products collected, true (unbounded) sum, result pending flag.
  longint unsigned m_sum = 0;
  int              m_cnt = 0;
  int              m_len = 0;
  bit              m_pend = 1'b0;
  int              cyc = 0;

  always @(posedge clk) begin
    if (rst || clr) begin
      m_pend = 1'b0;
      m_cnt  = 0;
      m_sum  = 0;
    end else if (m_pend) begin
      if (out_ready) m_pend = 1'b0;
    end else if (in_valid) begin
      if (m_cnt == 0) begin
        m_len = (len == 8'd0) ? 1 : int'(len);
        m_sum = 64'(prod);
      end else begin
        m_sum += 64'(prod);
      end
      m_cnt++;
      if (m_cnt == m_len) begin
        m_pend = 1'b1;
        m_cnt  = 0;
      end
    end
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    if (cyc > 0) begin
      chk("in_ready40",  64'(in_ready40),  64'(!rst && !m_pend));
      chk("out_valid40", 64'(out_valid40), 64'(!rst && m_pend));
      chk("acc40",       64'(acc40),       m_sum & M40);
      chk("ovf40",       64'(ovf40),       64'(m_sum > M40));
      chk("in_ready32",  64'(in_ready32),  64'(!rst && !m_pend));
      chk("out_valid32", 64'(out_valid32), 64'(!rst && m_pend));
      chk("acc32",       64'(acc32),       m_sum & M32);
      chk("ovf32",       64'(ovf32),       64'(m_sum > M32));
    end
  end

  // One input beat: present at a falling edge, accepted on the next rising edge.
  task automatic xfer(input logic [31:0] p, input logic [7:0] l);
    in_valid = 1'b1;
    prod     = p;
    len      = l;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; prod = 32'h1234; len = 8'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_acc", 64'(acc40), 64'd0);
    chk("rst_in_ready", 64'(in_ready40), 64'd0);
    chk("rst_out_valid", 64'(out_valid40), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready40), 64'd1);
    @(negedge clk);

    // Basic block of four.
    xfer(32'd1, 8'd4); xfer(32'd2, 8'd4); xfer(32'd3, 8'd4); xfer(32'd4, 8'd4);
    chk("basic_valid", 64'(out_valid40), 64'd1);
    chk("basic_acc", 64'(acc40), 64'd10);
    repeat (5) @(negedge clk);
    chk("basic_hold_acc", 64'(acc40), 64'd10);
    chk("basic_hold_in_ready", 64'(in_ready40), 64'd0);
    pop();
    chk("basic_idle_ready", 64'(in_ready40), 64'd1);

    // Longest block of maximum products.
    for (int i = 0; i < 254; i++) xfer(32'hFFFE_0001, 8'd255);
    chk("max_not_yet", 64'(out_valid40), 64'd0);
    xfer(32'hFFFE_0001, 8'd255);
    chk("max_valid", 64'(out_valid40), 64'd1);
    chk("max_acc40", 64'(acc40), 64'hFE_FE02_00FF);
    chk("max_ovf40", 64'(ovf40), 64'd0);
    chk("max_acc32", 64'(acc32), 64'hFE02_00FF);
    chk("max_ovf32", 64'(ovf32), 64'd1);
    pop();

    // len = 0 acts as a single-product block.
    xfer(32'hFFFF_FFFF, 8'd0);
    chk("len0_valid", 64'(out_valid40), 64'd1);
    chk("len0_acc", 64'(acc40), 64'h00_FFFF_FFFF);
    pop();

    // Gapped block; len changes mid-block are ignored.
    xfer(32'd7, 8'd3);
    repeat (2) @(negedge clk);
    xfer(32'd8, 8'd1);
    repeat (2) @(negedge clk);
    chk("gap_not_done", 64'(out_valid40), 64'd0);
    xfer(32'd9, 8'd1);
    chk("gap_acc", 64'(acc40), 64'd24);
    pop();

    // Overflow in the 32-bit instance, then cleared by the next block.
    xfer(32'hFFFF_FFFF, 8'd2); xfer(32'd2, 8'd2);
    chk("ovf_acc32", 64'(acc32), 64'd1);
    chk("ovf_flag32", 64'(ovf32), 64'd1);
    chk("ovf_acc40", 64'(acc40), 64'h01_0000_0001);
    pop();
    xfer(32'd5, 8'd1);
    chk("ovf_clear_flag32", 64'(ovf32), 64'd0);
    chk("ovf_clear_acc32", 64'(acc32), 64'd5);
    pop();

    // Abort with clr alongside a valid product.
    xfer(32'd10, 8'd4); xfer(32'd20, 8'd4);
    clr = 1'b1; in_valid = 1'b1; prod = 32'd30;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_acc", 64'(acc40), 64'd0);
    chk("clr_in_ready", 64'(in_ready40), 64'd1);
    xfer(32'd5, 8'd2); xfer(32'd6, 8'd2);
    chk("clr_next_acc", 64'(acc40), 64'd11);
    pop();

    // Same abort using rst.
    xfer(32'd10, 8'd4); xfer(32'd20, 8'd4);
    rst = 1'b1; in_valid = 1'b1; prod = 32'd30;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_abort_acc", 64'(acc40), 64'd0);
    xfer(32'd5, 8'd2); xfer(32'd6, 8'd2);
    chk("rst_next_acc", 64'(acc40), 64'd11);
    pop();

    // clr drops an unconsumed result.
    xfer(32'd3, 8'd1);
    chk("done_valid", 64'(out_valid40), 64'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_done_drop", 64'(out_valid40), 64'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

- Sequential accumulation stage directly downstream of the 16x16 array multiplier.
- Consumes the multiplier's 32-bit unsigned product through a valid/ready handshake and sums a programmable number of products into a wide accumulator.
- Presents the block sum, plus a sticky overflow flag, through a second valid/ready handshake.
- Forms the back end of the team's multiply-accumulate datapath: dot products and FIR taps.

## Interface

Parameters:
- ACC_W, default 40: accumulator and result width. Must be ≥ 32.
- CNT_W, default 8: width of the block-length field.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: reset, synchronous and active-high.
- prod, input, 32: unsigned product from the array multiplier.
- in_valid, input, 1: prod is valid this cycle.
- in_ready, output, 1: block can accept prod this cycle.
- len, input, CNT_W: number of products per block. Sampled only when the first product of a block is accepted. len = 0 is treated as 1.
- clr, input, 1: synchronous abort. Discards the current block and returns to IDLE.
- acc_out, output, ACC_W: block sum, held stable while out_valid = 1.
- ovf, output, 1: sticky flag; a carry out of bit ACC_W-1 occurred during this block.
- out_valid, output, 1: acc_out and ovf are valid.
- out_ready, input, 1: consumer takes the result.

## Operation

The FSM has three states: IDLE, ACCUM, DONE. A transfer occurs on a cycle where valid and ready are both high.

IDLE:
- in_ready = 1.
- On an input transfer:
  - acc ← zero-extended prod, ovf ← 0, cnt ← 1.
  - len_q ← max(len, 1).
  - Next state is DONE if len_q = 1, otherwise ACCUM.

ACCUM:
- in_ready = 1.
- On an input transfer:
  - {carry, acc} ← acc + prod, computed ACC_W+1 bits wide.
  - ovf ← ovf | carry; cnt ← cnt + 1.
  - Next state is DONE when cnt + 1 = len_q.
- With no transfer, state holds. Gaps in in_valid are allowed.

DONE:
- in_ready = 0, out_valid = 1; acc_out and ovf are frozen.
- On an output transfer (out_ready = 1), go to IDLE.
- With out_ready = 0, hold indefinitely.

General rules:
- in_ready and out_valid are decoded combinationally from the state register only. There is no combinational path from in_valid or out_ready to in_ready or out_valid.
- Both in_ready and out_valid are forced to 0 while rst = 1.
- A change on len mid-block is ignored.
- prod is ignored when in_valid = 0.
- Arithmetic is unsigned, with wrap modulo 2^ACC_W.
- With the default widths, overflow cannot occur (255 × (2^32−1) < 2^40).

## Timing

Reset:
- rst has priority over clr; clr has priority over any handshake.
- On a rst or clr edge: state ← IDLE, acc ← 0, cnt ← 0, ovf ← 0, len_q ← 0, out_valid = 0.
- in_ready = 1 in the first cycle after rst deasserts.

Latency and throughput:
- Each product is accumulated on the edge that accepts it.
- out_valid rises on the edge that accepts the len_q-th product, so it is visible in the next cycle. Latency from the last product to the result is 1 cycle.
- Input accepts one product per cycle within a block.
- There is a minimum one-cycle bubble between blocks, because DONE does not accept input.
- Full block period with no stalls: len_q + 1 cycles.

Boundary conditions:
- clr or rst in DONE drops the unconsumed result (out_valid → 0 the next cycle).
- clr on the same edge as a transfer: the transfer is discarded.
- A simultaneous input transfer in the cycle that DONE's output transfer completes is impossible, because in_ready = 0 in DONE.

## Test plan

- Reset: hold rst 3 cycles with in_valid = 1 and prod = 0x1234 → acc_out = 0, ovf = 0, out_valid = 0, in_ready = 0 during reset; in_ready = 1 in the first cycle after release; no product accumulated.
- Basic block: len = 4, prod 1, 2, 3, 4 back-to-back → out_valid high in the cycle after the 4th accept, acc_out = 10, ovf = 0. Hold out_ready = 0 for 5 cycles → outputs stable, in_ready = 0. Pulse out_ready → IDLE, in_ready = 1.
- Max products: len = 255, prod = 0xFFFE0001 (0xFFFF × 0xFFFF) each cycle → acc_out = 0xFEFE0200FF, ovf = 0, out_valid exactly 255 cycles after the first accept.
- len = 0 and gaps: len = 0, single prod 0xFFFFFFFF → acc_out = 0x00FFFFFFFF immediately after 1 accept. Then len = 3, prod 7, 8, 9 with 2 idle cycles between each (len changed to 1 mid-block) → acc_out = 24.
- Overflow (ACC_W = 32): len = 2, prod 0xFFFFFFFF, 0x00000002 → acc_out = 0x00000001, ovf = 1. Next block len = 1, prod 5 → ovf = 0, acc_out = 5.
- Abort: len = 4, accept 2 products, then assert clr together with in_valid → state IDLE, product discarded. New block len = 2, prod 5, 6 → acc_out = 11. Repeat with rst instead of clr → same result. clr while in DONE → out_valid drops the next cycle.
